vga_pixel_out: RTL and testbench

//  Downstream stage of the PPU. Accepts processed RGB332 bytes over the PPU's stb/ack output handshake
//  and buffers them in a small FIFO. Generates VGA hsync/vsync timing and drives the RGB pins.

---
 rtl/vga_pixel_out.sv | 177 +++++++++++++++++
 tb/tb_vga_pixel_out.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_out.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_out
// Brief    : RGB332 pixel FIFO with stb/ack intake, VGA sync timing, pixel
//            replication, frame_sync pulse and sticky underflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_REP  = 4,
    parameter int FIFO_AW  = 3,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         data_i,
    input  logic               stb_i,
    output logic               ack_i,
    output logic               hsync,
    output logic               vsync,
    output logic [2:0]         red,
    output logic [2:0]         green,
    output logic [1:0]         blue,
    output logic               frame_sync,
    output logic               underflow,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int PW       = $clog2(PIX_REP);
    localparam int LW       = FIFO_AW + 1;
    localparam int DEPTH    = 1 << FIFO_AW;

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(PIX_REP - 1);
    localparam logic [LW-1:0] FULL_LV = LW'(DEPTH);

    // ------------------------------------------------------------------
    // Timing counters
    // ------------------------------------------------------------------
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [PW-1:0] r_phase;

    logic w_h_last;
    logic w_v_last;
    logic w_active;
    logic w_hs_win;
    logic w_vs_win;
    logic w_fs;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);
    assign w_active = (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
    assign w_hs_win = (int'(r_h_cnt) >= HS_START) && (int'(r_h_cnt) < HS_END);
    assign w_vs_win = (int'(r_v_cnt) >= VS_START) && (int'(r_v_cnt) < VS_END);
    assign w_fs     = (r_h_cnt == '0) && (int'(r_v_cnt) == VS_START);

    // Phase restarts every line so replication stays aligned to h_cnt=0
    // even when H_TOTAL is not a multiple of PIX_REP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_phase <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_phase <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [LW-1:0] r_wptr;
    logic [LW-1:0] r_rptr;
    logic [LW-1:0] w_level;
    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_pop;
    logic          w_pop_ok;
    logic          w_uf;

    assign w_level  = r_wptr - r_rptr;
    assign w_full   = (w_level == FULL_LV);
    assign w_empty  = (w_level == '0);
    // Full/empty are judged on start-of-clock state: no bypass either way.
    assign w_wr     = stb_i && !ack_i && !w_full;
    assign w_pop    = w_active && (r_phase == '0);
    assign w_pop_ok = w_pop && !w_empty;
    assign w_uf     = w_pop && w_empty;

    assign fifo_level = w_level;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            ack_i  <= 1'b0;
        end else begin
            ack_i <= w_wr;
            if (w_wr) begin
                r_wptr <= r_wptr + LW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + LW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, all aligned one clock after the counters
    // ------------------------------------------------------------------
    logic [7:0] r_rgb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb      <= '0;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            frame_sync <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            hsync      <= w_hs_win ? SYNC_POL : ~SYNC_POL;
            vsync      <= w_vs_win ? SYNC_POL : ~SYNC_POL;
            frame_sync <= w_fs;

            if (!w_active) begin
                r_rgb <= '0;
            end else if (w_pop_ok) begin
                r_rgb <= r_mem[r_rptr[FIFO_AW-1:0]];
            end else if (w_uf) begin
                r_rgb <= '0;
            end

            if (w_uf) begin
                underflow <= 1'b1;
            end else if (w_fs) begin
                underflow <= 1'b0;
            end
        end
    end

    assign red   = r_rgb[7:5];
    assign green = r_rgb[4:2];
    assign blue  = r_rgb[1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel_out
// Brief    : Self-checking bench for vga_pixel_out with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_out;

    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 1;
    localparam int PIX_REP  = 2;
    localparam int FIFO_AW  = 2;
    localparam int DEPTH    = 1 << FIFO_AW;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       data = 8'h00;
    logic             stb = 1'b0;
    logic             ack;
    logic             hsync;
    logic             vsync;
    logic [2:0]       red;
    logic [2:0]       green;
    logic [1:0]       blue;
    logic             frame_sync;
    logic             underflow;
    logic [FIFO_AW:0] fifo_level;

    int tests_run    = 0;
    int tests_failed = 0;

    vga_pixel_out #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PIX_REP(PIX_REP), .FIFO_AW(FIFO_AW), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .data_i(data), .stb_i(stb), .ack_i(ack),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .frame_sync(frame_sync), .underflow(underflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Reference model: screen position from elapsed clocks, FIFO as a queue.
    int         cyc;
    logic [7:0] q[$];
    logic       m_ack, m_hs, m_vs, m_fs, m_uf;
    logic [7:0] m_rgb;
    int         p, h, v, sz;
    bit         act, pop, wr, uf_ev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; q.delete();
            m_ack = 0; m_hs = 1; m_vs = 1; m_fs = 0; m_uf = 0; m_rgb = 0;
        end else begin
            p   = cyc % FRAME;
            h   = p % H_TOTAL;
            v   = p / H_TOTAL;
            act = (h < H_ACTIVE) && (v < V_ACTIVE);
            m_hs = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
            m_vs = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
            m_fs = (h == 0) && (v == V_ACTIVE + V_FP);
            sz   = q.size();
            pop  = act && (h % PIX_REP == 0);
            uf_ev = 0;
            if (!act) m_rgb = 0;
            else if (pop) begin
                if (sz > 0) m_rgb = q.pop_front();
                else begin m_rgb = 0; uf_ev = 1; end
            end
            wr = stb && !m_ack && (sz < DEPTH);
            if (wr) q.push_back(data);
            m_ack = wr;
            if (uf_ev) m_uf = 1;
            else if (m_fs) m_uf = 0;
            cyc++;
        end
    end

    task automatic do_reset();
        rst = 1'b1; stb = 1'b0; data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 5000) begin @(negedge clk); g++; end
    endtask

    task automatic test_reset();
        logic [14:0] got;
        int k;
        do_reset();
        got = {ack, hsync, vsync, frame_sync, underflow, red, green, blue, fifo_level};
        tests_run++;
        if (got !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0}) begin
            tests_failed++;
            $display("FAIL reset_state got=%h want=%h", got, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0});
        end
        wait_cyc(56);
        k = 0; stb = 1'b1; data = 8'hA1;
        while (k < 3 && cyc < 80) begin
            @(negedge clk);
            if (m_ack) begin k++; data = data + 8'h01; if (k == 3) stb = 1'b0; end
        end
        wait_cyc(62);
        tests_run++;
        if (fifo_level !== 3'd3) begin
            tests_failed++; $display("FAIL reset_prefill level=%0d want=3", fifo_level);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (fifo_level !== 3'd0 || {red, green, blue} !== 8'h00 || hsync !== 1'b1 || vsync !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_async level=%0d rgb=%h hs=%b vs=%b want 0/00/1/1",
                     fifo_level, {red, green, blue}, hsync, vsync);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (frame_sync === 1'b1) begin k = i; break; end
        end
        tests_run++;
        if (k != H_TOTAL * (V_ACTIVE + V_FP) + 1) begin
            tests_failed++;
            $display("FAIL reset_first_frame_sync at=%0d want=%0d", k, H_TOTAL * (V_ACTIVE + V_FP) + 1);
        end
    endtask

    task automatic test_handshake();
        logic exp_ack;
        do_reset();
        wait_cyc(56);
        stb = 1'b1; data = 8'h11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_ack = (i < 2 * DEPTH) && (i % 2 == 0);
            tests_run++;
            if (ack !== exp_ack) begin
                tests_failed++; $display("FAIL handshake_ack step=%0d got=%b want=%b", i, ack, exp_ack);
            end
            if (m_ack) data = data + 8'h11;
        end
        tests_run++;
        if (fifo_level !== 3'(DEPTH)) begin
            tests_failed++; $display("FAIL handshake_full level=%0d want=%0d", fifo_level, DEPTH);
        end
        stb = 1'b0;
    endtask

    task automatic test_pixel_path();
        logic [7:0] bytes [4];
        logic [7:0] want;
        int k;
        bytes[0] = 8'hE0; bytes[1] = 8'h1C; bytes[2] = 8'h03; bytes[3] = 8'hFF;
        do_reset();
        wait_cyc(56);
        k = 0; stb = 1'b1; data = bytes[0];
        while (k < 4 && cyc < 90) begin
            @(negedge clk);
            if (m_ack) begin
                k++;
                if (k == 4) stb = 1'b0; else data = bytes[k];
            end
        end
        wait_cyc(FRAME);
        for (int i = 0; i < H_TOTAL; i++) begin
            @(negedge clk);
            want = (i < H_ACTIVE) ? bytes[i / PIX_REP] : 8'h00;
            tests_run++;
            if ({red, green, blue} !== want) begin
                tests_failed++;
                $display("FAIL pixel_path slot=%0d got=%h want=%h", i, {red, green, blue}, want);
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        @(negedge clk);
        tests_run++;
        if ({red, green, blue} !== 8'h00 || underflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL underflow_set rgb=%h uf=%b want 00/1", {red, green, blue}, underflow);
        end
        wait_cyc(56);
        stb = 1'b1; data = 8'h40;
        while (cyc < 70) begin @(negedge clk); if (m_ack) data = data + 8'h01; end
        tests_run++;
        if (underflow !== 1'b1) begin
            tests_failed++; $display("FAIL underflow_sticky got=%b want=1", underflow);
        end
        @(negedge clk); if (m_ack) data = data + 8'h01;
        tests_run++;
        if (frame_sync !== 1'b1 || underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL underflow_clear fs=%b uf=%b want 1/0", frame_sync, underflow);
        end
        while (cyc < 2 * FRAME) begin
            @(negedge clk); if (m_ack) data = data + 8'h01;
            tests_run++;
            if (underflow !== 1'b0) begin
                tests_failed++; $display("FAIL underflow_fed cyc=%0d got=%b want=0", cyc, underflow);
            end
        end
        stb = 1'b0;
    endtask

    task automatic test_full_pop();
        do_reset();
        wait_cyc(56);
        stb = 1'b1; data = 8'h70;
        while (cyc < FRAME) begin @(negedge clk); if (m_ack) data = data + 8'h01; end
        @(negedge clk);
        tests_run++;
        if (ack !== 1'b0 || fifo_level !== 3'(DEPTH - 1)) begin
            tests_failed++;
            $display("FAIL full_pop_refuse ack=%b level=%0d want 0/%0d", ack, fifo_level, DEPTH - 1);
        end
        @(negedge clk);
        tests_run++;
        if (ack !== 1'b1 || fifo_level !== 3'(DEPTH)) begin
            tests_failed++;
            $display("FAIL full_pop_next ack=%b level=%0d want 1/%0d", ack, fifo_level, DEPTH);
        end
        stb = 1'b0;
    endtask

    task automatic test_timing();
        int hs_low, vs_low, fs_cnt, first_hs;
        do_reset();
        hs_low = 0; vs_low = 0; fs_cnt = 0; first_hs = -1;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            @(negedge clk);
            if (hsync === 1'b0) begin hs_low++; if (first_hs < 0) first_hs = i; end
            if (vsync === 1'b0) vs_low++;
            if (frame_sync === 1'b1) fs_cnt++;
        end
        tests_run++;
        if (hs_low != 2 * V_TOTAL * H_SYNC || first_hs != H_ACTIVE + H_FP + 1) begin
            tests_failed++;
            $display("FAIL timing_hsync low=%0d first=%0d want %0d/%0d",
                     hs_low, first_hs, 2 * V_TOTAL * H_SYNC, H_ACTIVE + H_FP + 1);
        end
        tests_run++;
        if (vs_low != 2 * V_SYNC * H_TOTAL || fs_cnt != 2) begin
            tests_failed++;
            $display("FAIL timing_vsync low=%0d fs=%0d want %0d/2", vs_low, fs_cnt, 2 * V_SYNC * H_TOTAL);
        end
    endtask

    task automatic test_random();
        logic [22:0] got, want;
        do_reset();
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (!stb || m_ack) begin
                stb  = ($urandom_range(0, 3) != 0);
                data = 8'($urandom);
            end
            @(negedge clk);
            got  = {ack, hsync, vsync, frame_sync, underflow, red, green, blue, fifo_level, 5'd0};
            want = {m_ack, m_hs, m_vs, m_fs, m_uf, m_rgb, 3'(q.size()), 5'd0};
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, got, want);
            end
        end
        stb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_pixel_path();
        test_underflow();
        test_full_pop();
        test_timing();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
